muldiv_sequencer: RTL and testbench

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

---
 rtl/muldiv_sequencer_if.sv | 25 ++
 rtl/muldiv_sequencer.sv | 174 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - CPU-side request/result bundle for the HI/LO multiply-divide sequencer
interface muldiv_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        read_req;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  // CPU pipeline side: issues operations and reads HI/LO
  modport master (
    output start, op, rs, rt, read_req,
    input  busy, stall, done, hi, lo
  );

  // Sequencer side
  modport slave (
    input  start, op, rs, rt, read_req,
    output busy, stall, done, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - 32-cycle radix-2 MULT/MULTU/DIV/DIVU sequencer with HI/LO registers
module muldiv_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  muldiv_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  cnt_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [63:0] acc_q;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [31:0] opb_q;
  logic        is_div_q;
  logic        neg_a_q;
  logic        neg_b_q;
  logic        div0_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        done_q;

  // Request decode and operand magnitudes at accept time
  logic        accept;
  logic        op_is_md;
  logic        op_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  assign accept    = (state_q == S_IDLE) && bus.start;
  assign op_is_md  = ~bus.op[2];
  assign op_signed = ~bus.op[0];
  assign a_neg     = op_signed & bus.rs[31];
  assign b_neg     = op_signed & bus.rt[31];
  assign mag_a     = a_neg ? (~bus.rs + 32'd1) : bus.rs;
  assign mag_b     = b_neg ? (~bus.rt + 32'd1) : bus.rt;

  // One radix-2 step of each algorithm; the active one is selected by is_div_q
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [32:0] trial;
  logic [63:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opb_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    rem_sh   = acc_q[63:31];
    trial    = rem_sh - {1'b0, opb_q};
    // Remainder stays below the divisor, so a 33-bit trial never overflows;
    // a set MSB means the subtraction borrowed and the old remainder is kept.
    if (trial[32]) begin
      div_next = {rem_sh[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_next = {trial[31:0], acc_q[30:0], 1'b1};
    end
  end

  // Sign correction applied in FIX
  logic [63:0] prod_fix;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 64'd1) : acc_q;
    // Divide-by-zero leaves an all-ones quotient untouched. Its remainder is
    // |rs|, and restoring the dividend sign on it gives back rs exactly.
    quo_fix  = ((neg_a_q ^ neg_b_q) && !div0_q) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem_fix  = neg_a_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    if (is_div_q) begin
      fix_hi = rem_fix;
      fix_lo = quo_fix;
    end else begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end
  end

  // FSM state register; clk_enable low freezes the sequence
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else if (clk_enable) begin
      state_q <= state_d;
    end
  end

  // Next state: accept MULT/DIV in IDLE, 32 steps in ITER, one commit cycle in FIX
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept && op_is_md) state_d = S_ITER;
      S_ITER: if (cnt_q == 5'd0)      state_d = S_FIX;
      S_FIX:                          state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, HI/LO writes and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= 5'd0;
      acc_q    <= 64'd0;
      opb_q    <= 32'd0;
      is_div_q <= 1'b0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      div0_q   <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else if (clk_enable) begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op_is_md) begin
              cnt_q    <= 5'd31;
              is_div_q <= bus.op[1];
              neg_a_q  <= a_neg;
              neg_b_q  <= b_neg;
              div0_q   <= (bus.rt == 32'd0);
              if (bus.op[1]) begin
                acc_q <= {32'd0, mag_a};
                opb_q <= mag_b;
              end else begin
                acc_q <= {32'd0, mag_b};
                opb_q <= mag_a;
              end
            end else if (bus.op == OP_MTHI) begin
              hi_q <= bus.rs;
            end else if (bus.op == OP_MTLO) begin
              lo_q <= bus.rs;
            end
          end
        end
        S_ITER: begin
          acc_q <= is_div_q ? div_next : mul_next;
          if (cnt_q != 5'd0) begin
            cnt_q <= cnt_q - 5'd1;
          end
        end
        S_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = (state_q != S_IDLE);
  assign bus.stall = bus.busy & (bus.read_req | bus.start);
  assign bus.done  = done_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic clk_enable;

  muldiv_sequencer_if bus ();

  muldiv_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results as {hi, lo}
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] q;
    logic signed [63:0] r;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] uq;
    logic [63:0] ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'b000: return sa * sb;
      3'b001: return ua * ub;
      3'b010: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'b011: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic sb_check(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed empty scoreboard expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " hi/lo"}, {bus.hi, bus.lo}, e);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.op    = op;
    bus.rs    = a;
    bus.rt    = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat;
    int bcnt;
    logic changed;
    logic [63:0] prev;
    prev = {bus.hi, bus.lo};
    changed = 1'b0;
    exp_q.push_back(model(op, a, b));
    issue(op, a, b);
    lat = 0;
    bcnt = 0;
    while (!bus.done && lat < 200) begin
      if (bus.busy) bcnt++;
      if ({bus.hi, bus.lo} !== prev) changed = 1'b1;
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, 33);
    chk({tag, " busy cycles"}, bcnt, 33);
    chk({tag, " hi/lo held"}, changed, 1'b0);
    sb_check(tag);
    tick();
    chk({tag, " done width"}, bus.done, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int dcnt;
    int gaps;
    reset = 1'b1;
    clk_enable = 1'b1;
    bus.read_req = 1'b0;
    // start during reset must be ignored
    bus.start = 1'b1;
    bus.op = 3'b100;
    bus.rs = 32'hDEAD_BEEF;
    bus.rt = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    bus.start = 1'b0;
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset hi", bus.hi, 32'd0);
    chk("reset lo", bus.lo, 32'd0);
    chk("reset stall", bus.stall, 1'b0);

    run_op("mult_neg2x3", 3'b000, 32'hFFFF_FFFE, 32'd3);
    chk("mult_neg2x3 const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_max const", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
    run_op("div_neg7by2", 3'b010, 32'hFFFF_FFF9, 32'd2);
    run_op("divu_by0", 3'b011, 32'd7, 32'd0);
    run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_neg_by0", 3'b010, 32'hFFFF_FFF9, 32'd0);
    run_op("mult_mixed", 3'b000, 32'h1234_5678, 32'hF00D_CAFE);
    run_op("divu_big", 3'b011, 32'hFFFF_FFF0, 32'h0000_0123);

    // MTHI/MTLO commit at the accept edge; start+read_req in IDLE never stalls
    bus.read_req = 1'b1;
    bus.op = 3'b100;
    bus.rs = 32'hCAFE_0001;
    bus.start = 1'b1;
    #1;
    chk("idle start+read stall", bus.stall, 1'b0);
    tick();
    bus.start = 1'b0;
    bus.read_req = 1'b0;
    chk("mthi hi", bus.hi, 32'hCAFE_0001);
    chk("mthi busy", bus.busy, 1'b0);
    issue(3'b101, 32'hBEEF_0002, 32'd0);
    chk("mtlo lo", bus.lo, 32'hBEEF_0002);
    chk("mtlo hi kept", bus.hi, 32'hCAFE_0001);
    issue(3'b110, 32'h1111_1111, 32'd0);
    chk("nop hilo", {bus.hi, bus.lo}, 64'hCAFE_0001_BEEF_0002);
    chk("nop busy", bus.busy, 1'b0);

    // DIVU 100/7 with a 5-cycle enable gap and a pending MFHI/MFLO
    exp_q.push_back(model(3'b011, 32'd100, 32'd7));
    issue(3'b011, 32'd100, 32'd7);
    lat = 0;
    repeat (10) begin tick(); lat++; end
    clk_enable = 1'b0;
    repeat (5) begin tick(); lat++; end
    chk("gap busy", bus.busy, 1'b1);
    chk("gap hilo held", {bus.hi, bus.lo}, 64'hCAFE_0001_BEEF_0002);
    clk_enable = 1'b1;
    bus.read_req = 1'b1;
    #1;
    chk("gap stall", bus.stall, 1'b1);
    gaps = 0;
    while (!bus.done && lat < 200) begin
      if (!bus.stall) gaps++;
      tick();
      lat++;
    end
    chk("gap latency", lat, 38);
    chk("gap stall held", gaps, 0);
    chk("gap stall release", bus.stall, 1'b0);
    sb_check("divu_gap");
    chk("divu_gap const", {bus.hi, bus.lo}, {32'd2, 32'd14});
    bus.read_req = 1'b0;
    clk_enable = 1'b0;
    tick();
    tick();
    chk("done held disabled", bus.done, 1'b1);
    clk_enable = 1'b1;
    tick();
    chk("done drop", bus.done, 1'b0);

    // Reset mid-MULT, then MTLO
    issue(3'b000, 32'h0000_0005, 32'h0000_0007);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst mid busy", bus.busy, 1'b0);
    chk("rst mid hilo", {bus.hi, bus.lo}, 64'd0);
    chk("rst mid done", bus.done, 1'b0);
    issue(3'b101, 32'h0000_1234, 32'd0);
    chk("post rst mtlo", bus.lo, 32'h0000_1234);
    chk("post rst busy", bus.busy, 1'b0);

    // DIV issued during MULT is dropped
    exp_q.push_back(model(3'b000, 32'd1234, 32'd5678));
    issue(3'b000, 32'd1234, 32'd5678);
    lat = 0;
    repeat (5) begin tick(); lat++; end
    bus.op = 3'b010;
    bus.rs = 32'd9;
    bus.rt = 32'd3;
    bus.start = 1'b1;
    #1;
    chk("busy start stall", bus.stall, 1'b1);
    tick();
    lat++;
    bus.start = 1'b0;
    while (!bus.done && lat < 200) begin tick(); lat++; end
    chk("ignored latency", lat, 33);
    sb_check("mult_ignore");
    dcnt = 1;
    repeat (40) begin
      tick();
      if (bus.done) dcnt++;
    end
    chk("ignored done count", dcnt, 1);
    chk("ignored busy", bus.busy, 1'b0);
    chk("ignored hilo", {bus.hi, bus.lo}, 64'd1234 * 64'd5678);
    chk("scoreboard drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
